// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types and helper functions for param_data_memory
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } dmem_state_t;

  // Lower half of the array counts up from 0; upper half counts down from 0
  // in two's complement. The caller narrows the result to its word width.
  function automatic logic [63:0] init_pattern(input int idx, input int data_w, input int addr_w);
    logic [63:0] half;
    logic [63:0] val;
    logic [63:0] mask;
    half = 64'd1 << (addr_w - 1);
    if (64'(idx) < half) begin
      val = 64'(idx);
    end else begin
      val = -(64'(idx) - half);
    end
    mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
    return val & mask;
  endfunction

  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_init_seq.sv
// ============================================================================
// dmem_init_seq : post-reset sweep that walks every address once, owning the
//                 memory write port and holding busy until the sweep ends.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              clear,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              busy
);

  dmem_state_t       r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= INIT;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else if (r_state == INIT) begin
      r_ptr <= r_ptr + 1'b1;
      // Last entry written this edge; requests are accepted from next cycle.
      if (r_ptr == '1) begin
        r_state <= READY;
        r_busy  <= 1'b0;
      end
    end
  end

  assign init_we   = (r_state == INIT) && !clear;
  assign init_addr = r_ptr;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: rtl/param_data_memory.sv
// ============================================================================
// param_data_memory : DEPTH x DATA_W data memory, registered 1-cycle read with
//                     read_valid, multi-cycle init sweep. Optional per-word
//                     even parity enabled by macro DMEM_PARITY_EN.
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module param_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              signal_memread,
  input  logic              signal_memwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_to_write,
  output logic [DATA_W-1:0] data_out,
  output logic              read_valid,
  output logic              busy,
  output logic              parity_error
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef DMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_busy;

  dmem_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .clock     (clock),
    .clear     (clear),
    .init_we   (w_init_we),
    .init_addr (w_init_addr),
    .busy      (w_busy)
  );

  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_read_valid;

  logic              w_user_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;
  logic [DATA_W-1:0] w_pattern;

  // User requests are only honoured in READY and never in a clear cycle.
  assign w_user_ok = !w_busy && !clear;
  assign w_pattern = DATA_W'(init_pattern(32'(w_init_addr), DATA_W, ADDR_W));
  assign w_rd_word = r_mem[address];

  always_comb begin
    w_we      = 1'b0;
    w_wr_addr = address;
    w_wr_data = data_to_write;
    if (w_init_we) begin
      w_we      = 1'b1;
      w_wr_addr = w_init_addr;
      w_wr_data = w_pattern;
    end else if (w_user_ok && signal_memwrite) begin
      w_we = 1'b1;
    end
  end

`ifdef DMEM_PARITY_EN
  assign w_wr_word = {even_parity(64'(w_wr_data)), w_wr_data};
`else
  assign w_wr_word = w_wr_data;
`endif

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_wr_addr] <= w_wr_word;
    end
  end

  // Nonblocking storage update makes a same-address read return the old word.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_data_out   <= '0;
      r_read_valid <= 1'b0;
    end else if (w_user_ok && signal_memread) begin
      r_data_out   <= w_rd_word[DATA_W-1:0];
      r_read_valid <= 1'b1;
    end else begin
      r_read_valid <= 1'b0;
    end
  end

`ifdef DMEM_PARITY_EN
  logic r_parity_error;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_parity_error <= 1'b0;
    end else if (w_user_ok && signal_memread &&
                 (even_parity(64'(w_rd_word[DATA_W-1:0])) != w_rd_word[DATA_W])) begin
      r_parity_error <= 1'b1;
    end
  end

  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

  assign data_out   = r_data_out;
  assign read_valid = r_read_valid;
  assign busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_param_data_memory.sv
// ============================================================================
// tb_param_data_memory : self-checking bench for param_data_memory (default
//                        32x8 build) with directed vectors and a random phase.
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_param_data_memory;

  logic       clock = 1'b0;
  logic       clear;
  logic       signal_memread;
  logic       signal_memwrite;
  logic [4:0] address;
  logic [7:0] data_to_write;
  logic [7:0] data_out;
  logic       read_valid;
  logic       busy;
  logic       parity_error;

  param_data_memory #(.DATA_W(8), .ADDR_W(5)) dut (
    .clock           (clock),
    .clear           (clear),
    .signal_memread  (signal_memread),
    .signal_memwrite (signal_memwrite),
    .address         (address),
    .data_to_write   (data_to_write),
    .data_out        (data_out),
    .read_valid      (read_valid),
    .busy            (busy),
    .parity_error    (parity_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mdl [32];
  logic [7:0] exp_data;
  logic       exp_valid;
  rd_vec_t    vecs [9];

  function automatic logic [7:0] spec_pattern(input int i);
    int v;
    v = (i < 16) ? i : ((256 - (i - 16)) % 256);
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [4:0] a, input logic [7:0] d);
    signal_memread  = rd;
    signal_memwrite = wr;
    address         = a;
    data_to_write   = d;
    @(posedge clock);
    #1;
  endtask

  // Holds a read+write to address 4 active throughout the sweep.
  task automatic sweep_and_measure(input string tag);
    int   cnt;
    logic saw_valid;
    cnt       = 0;
    saw_valid = 1'b0;
    clear           = 1'b0;
    signal_memread  = 1'b1;
    signal_memwrite = 1'b1;
    address         = 5'd4;
    data_to_write   = 8'h55;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock);
      #1;
      cnt++;
      if (read_valid) saw_valid = 1'b1;
      if (!busy) break;
    end
    check({tag, "_busy_len"}, 32'(cnt), 32'd32);
    check({tag, "_no_valid_busy"}, {31'd0, saw_valid}, 32'd0);
    signal_memread  = 1'b0;
    signal_memwrite = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = spec_pattern(i);
  endtask

  task automatic random_phase(input int n);
    logic       rd;
    logic       wr;
    logic [4:0] a;
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      d  = 8'($urandom_range(0, 255));
      if (rd) exp_data = mdl[a];
      exp_valid = rd;
      if (wr) mdl[a] = d;
      cyc(rd, wr, a, d);
      check("rand_valid", {31'd0, read_valid}, {31'd0, exp_valid});
      check("rand_data", {24'd0, data_out}, {24'd0, exp_data});
    end
  endtask

  initial begin
    vecs[0] = '{5'd0,  8'h00};
    vecs[1] = '{5'd3,  8'h03};
    vecs[2] = '{5'd4,  8'h04};
    vecs[3] = '{5'd15, 8'h0F};
    vecs[4] = '{5'd16, 8'h00};
    vecs[5] = '{5'd17, 8'hFF};
    vecs[6] = '{5'd20, 8'hFC};
    vecs[7] = '{5'd31, 8'hF1};
    vecs[8] = '{5'd8,  8'h08};

    clear           = 1'b1;
    signal_memread  = 1'b0;
    signal_memwrite = 1'b0;
    address         = '0;
    data_to_write   = '0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_valid", {31'd0, read_valid}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_parity", {31'd0, parity_error}, 32'd0);

    sweep_and_measure("init1");

    foreach (vecs[i]) begin
      cyc(1'b1, 1'b0, vecs[i].addr, 8'h00);
      check("tbl_valid", {31'd0, read_valid}, 32'd1);
      check("tbl_data", {24'd0, data_out}, {24'd0, vecs[i].exp});
    end
    cyc(1'b0, 1'b0, 5'd0, 8'h00);
    check("idle_valid", {31'd0, read_valid}, 32'd0);
    check("idle_hold", {24'd0, data_out}, 32'h08);

    cyc(1'b0, 1'b1, 5'd7, 8'hA5);
    check("wr7_no_valid", {31'd0, read_valid}, 32'd0);
    cyc(1'b1, 1'b0, 5'd7, 8'h00);
    check("rd7_valid", {31'd0, read_valid}, 32'd1);
    check("rd7_data", {24'd0, data_out}, 32'hA5);
    mdl[7] = 8'hA5;

    cyc(1'b1, 1'b1, 5'd9, 8'h3C);
    check("rw9_old", {24'd0, data_out}, 32'h09);
    cyc(1'b1, 1'b0, 5'd9, 8'h00);
    check("rd9_new", {24'd0, data_out}, 32'h3C);
    mdl[9]    = 8'h3C;
    exp_data  = 8'h3C;

    random_phase(400);

    // Clear in READY together with a read: the read must be discarded.
    clear          = 1'b1;
    signal_memread = 1'b1;
    address        = 5'd5;
    @(posedge clock); #1;
    check("clr_kill_valid", {31'd0, read_valid}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    check("clr_data", {24'd0, data_out}, 32'd0);
    clear          = 1'b0;
    signal_memread = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
    end
    check("mid_sweep_busy", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    @(posedge clock); #1;
    check("restart_busy", {31'd0, busy}, 32'd1);
    sweep_and_measure("init2");
    exp_data = 8'h00;

    random_phase(200);
    check("parity_quiet", {31'd0, parity_error}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
